flex_counter_mc: RTL and testbench

// - Multi-channel successor to the single-channel flex counter: NUM_CH independent counters share one clock/reset.
// - Each channel adds up/down counting, synchronous load and a wrap/saturate mode.
// - Each channel outputs a registered terminal flag and a one-cycle wrap pulse.
// - Used by the USB/AHB timing logic (bit-stuff, byte, timeout, packet-length counting) in place of separate counter instances.

---
 rtl/flex_counter_mc.sv | 104 ++++++++++
 tb/tb_flex_counter_mc.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/flex_counter_mc.sv
// NUM_CH independent up/down counters with load, clear, wrap/saturate mode,
// registered terminal flag and wrap pulse. Define FLEX_CNT_STICKY_EN for sticky wrap status.
module flex_counter_mc #(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned NUM_CH       = 2
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              count_down,
  input  logic [NUM_CH-1:0]              sat_mode,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              wrap_pulse,
  output logic [NUM_CH-1:0]              wrap_sticky,
  input  logic [NUM_CH-1:0]              sticky_clr
);

  localparam int unsigned W = NUM_CNT_BITS;

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] r;
    logic [W-1:0] lv;
    logic         flag_q;
    logic         flag_d;
    logic         wrap_q;
    logic         wrap_d;

    assign r  = rollover_val[i*W +: W];
    assign lv = load_val[i*W +: W];

    // Next-state: clear > load > count step > hold; R==0 disables stepping.
    always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clear[i]) begin
        cnt_d = '0;
      end else if (load[i]) begin
        cnt_d = lv;
      end else if (count_enable[i] && (r != '0)) begin
        if (!count_down[i]) begin
          if (cnt_q < r) begin
            cnt_d = cnt_q + W'(1);
          end else if (!sat_mode[i]) begin
            cnt_d  = W'(1);
            wrap_d = 1'b1;
          end
        end else begin
          if (cnt_q > W'(1)) begin
            cnt_d = cnt_q - W'(1);
          end else if (!sat_mode[i]) begin
            cnt_d  = r;
            wrap_d = 1'b1;
          end
        end
      end
      flag_d = (r != '0) && (count_down[i] ? (cnt_d <= W'(1)) : (cnt_d >= r));
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        cnt_q  <= '0;
        flag_q <= 1'b0;
        wrap_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        flag_q <= flag_d;
        wrap_q <= wrap_d;
      end
    end

    assign count_out[i*W +: W] = cnt_q;
    assign rollover_flag[i]    = flag_q;
    assign wrap_pulse[i]       = wrap_q;

`ifdef FLEX_CNT_STICKY_EN
    logic sticky_q;

    // Set takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        sticky_q <= 1'b0;
      end else if (wrap_d) begin
        sticky_q <= 1'b1;
      end else if (sticky_clr[i]) begin
        sticky_q <= 1'b0;
      end
    end

    assign wrap_sticky[i] = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr[i];
    assign wrap_sticky[i]    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_flex_counter_mc.sv
// Directed table-driven bench for flex_counter_mc (W=4, 2 channels), plus
// hand sequences for async reset, R==0 and sticky wrap status.
module tb_flex_counter_mc;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] clear, count_enable, count_down, sat_mode, load, sticky_clr;
  logic [7:0] load_val, rollover_val;
  logic [7:0] count_out;
  logic [1:0] rollover_flag, wrap_pulse, wrap_sticky;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] clr, en, dn, sat, ld;
    logic [7:0] lv, rv;
    logic [7:0] cnt;
    logic [1:0] flag, wrap;
  } vec_t;

  vec_t vecs[$];

  flex_counter_mc #(.NUM_CNT_BITS(4), .NUM_CH(2)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
    .count_down(count_down), .sat_mode(sat_mode), .load(load),
    .load_val(load_val), .rollover_val(rollover_val), .count_out(count_out),
    .rollover_flag(rollover_flag), .wrap_pulse(wrap_pulse),
    .wrap_sticky(wrap_sticky), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] clr, en, dn, sat, ld, input logic [7:0] lv, rv,
                     input logic [7:0] cnt, input logic [1:0] flag, wrap);
    vec_t v;
    v.clr = clr; v.en = en; v.dn = dn; v.sat = sat; v.ld = ld;
    v.lv = lv; v.rv = rv; v.cnt = cnt; v.flag = flag; v.wrap = wrap;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0] exp_st;
    logic [1:0] exp_sq;

    // Ch0 up, wrap, R=5 (ch1 idle, R=0)
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h05, 8'h01, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h05, 8'h02, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h05, 8'h03, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h05, 8'h04, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h05, 8'h05, 2'b01, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h05, 8'h01, 2'b00, 2'b01);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h05, 8'h02, 2'b00, 2'b00);
    add(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h05, 8'h03, 2'b00, 2'b00);
    // Ch1 down, wrap, R=3: load 3 then 5 steps; ch0 holds at 3
    add(2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 8'h30, 8'h35, 8'h33, 2'b00, 2'b00);
    add(2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h30, 8'h35, 8'h23, 2'b00, 2'b00);
    add(2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h30, 8'h35, 8'h13, 2'b10, 2'b00);
    add(2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h30, 8'h35, 8'h33, 2'b00, 2'b10);
    add(2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h30, 8'h35, 8'h23, 2'b00, 2'b00);
    add(2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 8'h30, 8'h35, 8'h13, 2'b10, 2'b00);
    // Ch0 sat up, R=4, after clear
    add(2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 8'h00, 8'h34, 8'h10, 2'b10, 2'b00);
    add(2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 8'h00, 8'h34, 8'h11, 2'b10, 2'b00);
    add(2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 8'h00, 8'h34, 8'h12, 2'b10, 2'b00);
    add(2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 8'h00, 8'h34, 8'h13, 2'b10, 2'b00);
    add(2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 8'h00, 8'h34, 8'h14, 2'b11, 2'b00);
    add(2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 8'h00, 8'h34, 8'h14, 2'b11, 2'b00);
    add(2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 8'h00, 8'h34, 8'h14, 2'b11, 2'b00);
    add(2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 8'h00, 8'h34, 8'h14, 2'b11, 2'b00);
    // Priority: clear+load+enable, then load 9 > R=5, then wrap to 1
    add(2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 8'h09, 8'h35, 8'h10, 2'b10, 2'b00);
    add(2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 8'h09, 8'h35, 8'h19, 2'b11, 2'b00);
    add(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 8'h09, 8'h35, 8'h11, 2'b10, 2'b01);
    // Ch0 R=0: enable ignored, clear still acts, flag 0 either direction
    add(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 8'h00, 8'h30, 8'h11, 2'b10, 2'b00);
    add(2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 8'h00, 8'h30, 8'h10, 2'b10, 2'b00);
    add(2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 8'h00, 8'h30, 8'h10, 2'b10, 2'b00);
    // Ch1 direction change re-evaluates flag against held count
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h30, 8'h10, 2'b00, 2'b00);

    n_rst = 1'b0;
    clear = '0; count_enable = '0; count_down = '0; sat_mode = '0; load = '0;
    sticky_clr = '0; load_val = '0; rollover_val = '0;
    #12;
    chk("reset_count", 32'(count_out), 32'h0);
    chk("reset_flag", 32'(rollover_flag), 32'h0);
    chk("reset_wrap", 32'(wrap_pulse), 32'h0);
    chk("reset_sticky", 32'(wrap_sticky), 32'h0);
    n_rst = 1'b1;

    exp_st = 2'b00;
    foreach (vecs[k]) begin
      clear = vecs[k].clr; count_enable = vecs[k].en; count_down = vecs[k].dn;
      sat_mode = vecs[k].sat; load = vecs[k].ld;
      load_val = vecs[k].lv; rollover_val = vecs[k].rv;
      step();
      chk($sformatf("v%0d_count", k), 32'(count_out), 32'(vecs[k].cnt));
      chk($sformatf("v%0d_flag", k), 32'(rollover_flag), 32'(vecs[k].flag));
      chk($sformatf("v%0d_wrap", k), 32'(wrap_pulse), 32'(vecs[k].wrap));
`ifdef FLEX_CNT_STICKY_EN
      exp_st = exp_st | vecs[k].wrap;
`endif
      chk($sformatf("v%0d_sticky", k), 32'(wrap_sticky), 32'(exp_st));
    end

    // Async reset mid-count: ch0=3, ch1=7 (ch1 flagged at R=7)
    clear = '0; sat_mode = '0; count_down = '0; count_enable = '0;
    load = 2'b11; load_val = 8'h73; rollover_val = 8'h77;
    step();
    chk("pre_rst_count", 32'(count_out), 32'h73);
    chk("pre_rst_flag", 32'(rollover_flag), 32'h2);
    load = '0; count_enable = 2'b11;
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count_out), 32'h0);
    chk("async_rst_flag", 32'(rollover_flag), 32'h0);
    chk("async_rst_wrap", 32'(wrap_pulse), 32'h0);
    chk("async_rst_sticky", 32'(wrap_sticky), 32'h0);
    count_enable = '0; rollover_val = 8'h00;
    #2 n_rst = 1'b1;

    // R=0 on both channels with enable: stays 0, flag 0
    count_enable = 2'b11;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("r0_count_%0d", j), 32'(count_out), 32'h0);
      chk($sformatf("r0_flag_%0d", j), 32'(rollover_flag), 32'h0);
    end

    // Sticky: ch0 R=1 up wrap; clear coinciding with a wrap loses, clear alone wins
    rollover_val = 8'h01; count_enable = 2'b01;
    step();
    chk("st_count_1", 32'(count_out), 32'h01);
    chk("st_wrap_1", 32'(wrap_pulse), 32'h0);
    chk("st_sticky_1", 32'(wrap_sticky), 32'h0);
    step();
    chk("st_wrap_2", 32'(wrap_pulse), 32'h1);
`ifdef FLEX_CNT_STICKY_EN
    exp_sq = 2'b01;
`else
    exp_sq = 2'b00;
`endif
    chk("st_sticky_2", 32'(wrap_sticky), 32'(exp_sq));
    sticky_clr = 2'b01;
    step();
    chk("st_wrap_3", 32'(wrap_pulse), 32'h1);
    chk("st_sticky_set_wins", 32'(wrap_sticky), 32'(exp_sq));
    count_enable = '0;
    step();
    chk("st_wrap_4", 32'(wrap_pulse), 32'h0);
    chk("st_sticky_cleared", 32'(wrap_sticky), 32'h0);
    sticky_clr = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
